// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: mdop encodings and FSM states.
// MADD/MADDU encodings exist here regardless of MDU_MADD_EN; only the datapath gates them.
package mdu_defs;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath producing the next {HI,LO} pair.
// Optional MADD/MADDU accumulate is compiled in with `define MDU_MADD_EN.
module mdu_core
  import mdu_defs::*;
(
  input  mdop_e       op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_next_o,
  output logic [31:0] lo_next_o
);

  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_res, r_res;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // One unsigned divider serves both DIV and DIVU; signed division runs on magnitudes.
  assign div_signed = (op_i == OP_DIV);
  assign a_mag = (div_signed && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign b_mag = (div_signed && b_i[31]) ? (~b_i + 32'd1) : b_i;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_res = (div_signed && (a_i[31] ^ b_i[31])) ? (~q_mag + 32'd1) : q_mag;
  assign r_res = (div_signed && a_i[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hi_next_o = hi_i;
    lo_next_o = lo_i;
    case (op_i)
      OP_MULT:  {hi_next_o, lo_next_o} = prod_s;
      OP_MULTU: {hi_next_o, lo_next_o} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_i != 32'd0) begin
          hi_next_o = r_res;
          lo_next_o = q_res;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_next_o, lo_next_o} = {hi_i, lo_i} + prod_s;
      OP_MADDU: {hi_next_o, lo_next_o} = {hi_i, lo_i} + prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with busy.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  mdop_e            op_q, op_in;
  logic             busy_q;
  logic             is_mul, is_div;
  logic [31:0]      hi_d, lo_d;

  assign op_in = mdop_e'(mdop);
`ifdef MDU_MADD_EN
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                  (op_in == OP_MADD) || (op_in == OP_MADDU);
`else
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU);
`endif
  assign is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);

  mdu_core u_core (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .hi_next_o (hi_d),
    .lo_next_o (lo_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= op_in;
              cnt_q   <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else if (op_in == OP_MTHI) begin
              hi_q <= A;
            end else if (op_in == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_RUN: begin
          // A start arriving here is deliberately ignored.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// mid-operation sequences, and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op with a single-cycle start, then count busy cycles (bounded at 40).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; mdop = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Reference model: plain arithmetic on the architectural HI/LO pair.
  logic [31:0] m_hi, m_lo;

  function automatic int model_apply(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin {m_hi, m_lo} = 64'(sa * sb); return 5; end
      3'd1: begin {m_hi, m_lo} = {32'd0, a} * {32'd0, b}; return 5; end
      3'd2: begin
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        return 10;
      end
      3'd3: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        return 10;
      end
      3'd4: begin m_hi = a; return 0; end
      3'd5: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      3'd6: begin acc = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = acc; return 5; end
      3'd7: begin acc = {m_hi, m_lo} + {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = acc; return 5; end
`endif
      default: return 0;
    endcase
  endfunction

  vec_t vecs[10];

  initial begin
    int cyc, exp_cyc;
    logic [2:0] op;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h0, 32'h0, 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{32'h0, 32'h0, 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{32'h0, 32'h0, 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{32'h11, 32'h22, 3'd3, 32'd7, 32'd0, 10, 32'h00000011, 32'h00000022};
    vecs[4] = '{32'h5, 32'h6, 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000};
    vecs[5] = '{32'h0, 32'h0, 3'd3, 32'd100, 32'd7, 10, 32'h2, 32'hE};
    vecs[6] = '{32'h0, 32'h0, 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD};
    vecs[7] = '{32'h0, 32'h0, 3'd0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0};
    vecs[8] = '{32'h9, 32'hA, 3'd4, 32'h55, 32'h0, 0, 32'h55, 32'hA};
    vecs[9] = '{32'h9, 32'hA, 3'd2, 32'hAA, 32'h0, 10, 32'h9, 32'hA};

    reset = 1'b1; start = 1'b0; mdop = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(3'd4, vecs[i].pre_hi, 32'h0, cyc);
      run_op(3'd5, vecs[i].pre_lo, 32'h0, cyc);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
    end

    // start(DIV) pulsed while a MULT is in flight must be ignored.
    @(negedge clk);
    start = 1'b1; mdop = 3'd0; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_ignore_cycles", 32'(cyc), 32'd5);
    check("busy_ignore_hi", HI, 32'h0);
    check("busy_ignore_lo", LO, 32'h1E);

    // Reset during RUN aborts the multiply and clears everything.
    run_op(3'd4, 32'h77, 32'h0, cyc);
    @(negedge clk);
    start = 1'b1; mdop = 3'd0; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run_busy", {31'd0, busy}, 32'h0);
    check("rst_run_hi", HI, 32'h0);
    check("rst_run_lo", LO, 32'h0);
    repeat (6) @(negedge clk);
    check("rst_run_late_lo", LO, 32'h0);

    // Randomized ops against the reference model, from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      exp_cyc = model_apply(op, ra, rb);
      run_op(op, ra, rb, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cyc), 32'(exp_cyc));
      check($sformatf("rnd%0d_op%0d_hi", i, op), HI, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", i, op), LO, m_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
